vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 111 +++++++++++
 tb/tb_vga_timing_gen.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides clk down to pixel slots, runs the
// horizontal/vertical raster counters, and produces registered sync,
// blanking and frame-boundary outputs aligned with the counters.
module vga_timing_gen #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515,
  parameter int unsigned PIX_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam logic [2:0] DIV_MAX   = 3'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_L  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_L  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_S_L = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_E_L = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_S_L = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_E_L = 10'(V_ACT_END);

  logic [2:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       bright_q, bright_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;
  logic       adv;

  // The slot pulse is gated by reset so it reads 0 while rst is low even
  // when PIX_DIV=1 makes the divider compare permanently true.
  assign adv    = (div_q == DIV_MAX);
  assign pix_en = rst & adv;

  // Next-state counters; sync/blank are decoded from the next-state values
  // so the registered outputs line up with the counters they describe.
  always_comb begin
    div_d = adv ? '0 : div_q + 3'd1;
    h_d   = h_q;
    v_d   = v_q;
    fs_d  = 1'b0;
    fc_d  = fc_q;
    if (adv) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fs_d = 1'b1;
          fc_d = fc_q + 8'd1;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hsync_d  = !(h_d < H_SYNC_L);
    vsync_d  = !(v_d < V_SYNC_L);
    bright_d = (h_d >= H_ACT_S_L) && (h_d < H_ACT_E_L) &&
               (v_d >= V_ACT_S_L) && (v_d < V_ACT_E_L);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      fs_q     <= 1'b0;
      fc_q     <= '0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      fs_q     <= fs_d;
      fc_q     <= fc_d;
    end
  end

  assign hCount      = h_q;
  assign vCount      = v_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign bright      = bright_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two instances (PIX_DIV=4 and
// PIX_DIV=1) on a reduced raster, compared every clock against a model
// that derives all outputs from the number of clocks since reset release.
module tb_vga_timing_gen;

  localparam int unsigned HT  = 20;
  localparam int unsigned HS  = 3;
  localparam int unsigned HAS = 5;
  localparam int unsigned HAE = 18;
  localparam int unsigned VT  = 12;
  localparam int unsigned VS  = 2;
  localparam int unsigned VAS = 3;
  localparam int unsigned VAE = 10;
  localparam int unsigned FRAME_PIX = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       pe4, hs4, vs4, br4, fs4;
  logic [9:0] h4, v4;
  logic [7:0] fc4;
  logic       pe1, hs1, vs1, br1, fs1;
  logic [9:0] h1, v1;
  logic [7:0] fc1;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned k        = 0;
  int unsigned fs4_seen = 0;
  int unsigned fs1_seen = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .PIX_DIV(4)
  ) u_div4 (
    .clk(clk), .rst(rst), .pix_en(pe4), .hCount(h4), .vCount(v4),
    .hSync(hs4), .vSync(vs4), .bright(br4), .frame_start(fs4),
    .frame_cnt(fc4)
  );

  vga_timing_gen #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACT_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .PIX_DIV(1)
  ) u_div1 (
    .clk(clk), .rst(rst), .pix_en(pe1), .hCount(h1), .vCount(v1),
    .hSync(hs1), .vSync(vs1), .bright(br1), .frame_start(fs1),
    .frame_cnt(fc1)
  );

  // Expected {pix_en,h,v,hSync,vSync,bright,frame_start,frame_cnt} after
  // kk clock edges since reset release, from raster arithmetic alone.
  function automatic logic [32:0] model(input int unsigned d, input int unsigned kk);
    int unsigned p, h, v, fr;
    logic pe, hs, vs, br, fs;
    p  = kk / d;
    h  = p % HT;
    v  = (p / HT) % VT;
    fr = p / FRAME_PIX;
    pe = ((kk % d) == d - 1);
    hs = (h >= HS);
    vs = (v >= VS);
    br = (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE);
    fs = (kk > 0) && ((kk % d) == 0) && ((p % FRAME_PIX) == 0);
    return {pe, 10'(h), 10'(v), hs, vs, br, fs, 8'(fr % 256)};
  endfunction

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_d4"}, {pe4, h4, v4, hs4, vs4, br4, fs4, fc4}, model(4, k));
    chk({tag, "_d1"}, {pe1, h1, v1, hs1, vs1, br1, fs1, fc1}, model(1, k));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_d4"}, {pe4, h4, v4, hs4, vs4, br4, fs4, fc4}, '0);
    chk({tag, "_d1"}, {pe1, h1, v1, hs1, vs1, br1, fs1, fc1}, '0);
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, "_fs4"}, 33'(fs4_seen), 33'(k / (4 * FRAME_PIX)));
    chk({tag, "_fs1"}, 33'(fs1_seen), 33'(k / FRAME_PIX));
  endtask

  task automatic run(input int unsigned n, input string tag);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (fs4) fs4_seen++;
      if (fs1) fs1_seen++;
      check_model(tag);
    end
  endtask

  // Called at a negedge: drops reset mid-cycle, checks the immediate clear,
  // holds across edges, then releases and restarts the model.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b0;
    #1 check_zero({tag, "_async"});
    repeat (2) @(negedge clk);
    check_zero({tag, "_hold"});
    rst = 1'b1;
    k = 0;
    fs4_seen = 0;
    fs1_seen = 0;
    #1 check_model({tag, "_rel"});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("por");
    rst = 1'b1;
    k = 0;
    #1 check_model("release");

    run(3 * 4 * FRAME_PIX, "frames3");
    check_pulses("frames3");

    for (int i = 0; i < 3; i++) begin
      run($urandom_range(1500, 100), "pre_rst");
      pulse_reset("midrst");
      run($urandom_range(1200, 50), "post_rst");
      check_pulses("post_rst");
    end

    pulse_reset("wrap");
    run(256 * FRAME_PIX + $urandom_range(400, 10), "fc_wrap");
    check_pulses("fc_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
